recv_ctrl_mc: RTL and testbench
===============================

RECV_CTRL_MC -- requirements
Module: recv_ctrl_mc

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of receive channels.
REQ-002 The block SHALL have parameter DFX_WIDTH, default 2: source/destination DFX id width.
REQ-003 The block SHALL have parameter SEQ_NUM_WIDTH, default 3: sequence number width.
REQ-004 The block SHALL have parameter CH_W, default clog2(NUM_CH) (minimum 1): channel index width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port pkt_valid, input, NUM_CH bits: per-channel packet valid.
REQ-008 The block SHALL have port pkt_type, input, NUM_CH bits: 1 = ACK packet, 0 = data packet.
REQ-009 The block SHALL have ports pkt_src_dfx and pkt_dst_dfx, input, NUM_CH*DFX_WIDTH bits: per-channel source and destination ids.
REQ-010 The block SHALL have ports pkt_sn and pkt_rn, input, NUM_CH*SEQ_NUM_WIDTH bits: per-channel send and request numbers.
REQ-011 The block SHALL have port pkt_ready, output, NUM_CH bits: one-hot accept.
REQ-012 The block SHALL have ports ack_rx_valid (output, 1), ack_rx_rn (output, SEQ_NUM_WIDTH), ack_rx_src_dfx (output, DFX_WIDTH) and ack_rx_ready (input, 1): received-ACK report to the send controller.
REQ-013 The block SHALL have ports ack_tx_start (output, 1), ack_tx_src_dfx (output, DFX_WIDTH), ack_tx_dst_dfx (output, DFX_WIDTH), ack_tx_rn (output, SEQ_NUM_WIDTH) and ack_tx_done (input, 1): ACK-creation request to the fragmenter.
REQ-014 The block SHALL have ports dlv_valid (output, 1), dlv_src_dfx (output, DFX_WIDTH), dlv_ch (output, CH_W) and dlv_done (input, 1): data-delivery report to the total controller.

Function
REQ-015 The FSM SHALL have states IDLE, PROCESS, DELIVER, ACK_START, ACK_WAIT and ACK_RX.
REQ-016 In IDLE with any pkt_valid set, the block SHALL grant exactly one channel, chosen round-robin starting at rr_ptr.
- pkt_ready SHALL be combinational and asserted only for the granted channel, only in IDLE.
- The block SHALL register that channel's fields and index in the same cycle (the accept cycle T), then go to PROCESS.
REQ-017 After each accept, rr_ptr SHALL become grant+1 modulo NUM_CH.
REQ-018 In PROCESS, an ACK packet (type 1) SHALL go to ACK_RX; a data packet SHALL go to DELIVER or ACK_START according to REQ-024 and REQ-025.
REQ-019 In ACK_RX, the block SHALL hold ack_rx_valid=1 with ack_rx_rn=captured rn and ack_rx_src_dfx=captured src until ack_rx_ready=1, then go to IDLE.
- ack_rx_valid SHALL first be high at cycle T+2.
REQ-020 In DELIVER, the block SHALL hold dlv_valid=1 with the captured src and channel until dlv_done=1, then go to ACK_START.
- dlv_done outside DELIVER SHALL be ignored.
REQ-021 In ACK_START, ack_tx_start SHALL pulse for exactly one cycle, then the FSM goes to ACK_WAIT.
- ack_tx_src_dfx SHALL be the captured dst; ack_tx_dst_dfx SHALL be the captured src.
- The ACK fields SHALL be held stable through ACK_WAIT.
REQ-022 In ACK_WAIT, the FSM SHALL return to IDLE when ack_tx_done=1.
- ack_tx_done SHALL be sampled only in ACK_WAIT; a done coincident with the start pulse SHALL be ignored.
REQ-023 Sequence arithmetic SHALL be modulo 2^SEQ_NUM_WIDTH; wrap from max to 0 SHALL be legal.
REQ-024 An in-order data packet SHALL go to DELIVER, and its ACK SHALL carry ack_tx_rn = sn+1.
REQ-025 An out-of-order data packet (only possible with RECV_SEQ_CHECK_EN) SHALL go directly to ACK_START, skipping DELIVER, with ack_tx_rn = expected_sn[src].
REQ-026 ack_rx_valid, dlv_valid and ack_tx_start SHALL be mutually exclusive.
- While not in IDLE, pkt_ready SHALL be 0 and all channels SHALL back-pressure.

Reset
REQ-027 When rst=1 at a clock edge, the FSM SHALL enter IDLE from any state, including mid-handshake.
- Outputs SHALL then be: ack_rx_valid=0, dlv_valid=0, ack_tx_start=0, and all data outputs 0.
- rr_ptr SHALL be 0 and all expected_sn entries SHALL be 0.
REQ-028 pkt_ready SHALL be 0 while rst=1.

Configuration
REQ-029 Macro RECV_SEQ_CHECK_EN defined: the block SHALL keep a 2^DFX_WIDTH-entry table expected_sn[src].
- Data with sn == expected_sn[src] is in-order; expected_sn[src] SHALL increment on the DELIVER-to-ACK_START transition.
- Any other sn is out-of-order: no delivery, and the table is unchanged.
REQ-030 Macro RECV_SEQ_CHECK_EN undefined: the table SHALL not exist and every data packet SHALL be treated as in-order.

Verification
REQ-031 Data on ch2 (src=1, dst=3, sn=0), ack_rx_ready tied 1, dlv_done tied 1, ack_tx_done after 3 cycles -> pkt_ready[2] high at T; dlv_valid at T+2 with dlv_ch=2; ack_tx_start one cycle with src=3, dst=1, rn=1; back to IDLE.
REQ-032 pkt_valid=4'b1111 held, all data, immediate dones -> grants in order ch0, ch1, ch2, ch3, ch0.
REQ-033 ACK packet on ch1 (rn=5, src=2), ack_rx_ready low for 4 cycles -> ack_rx_valid held with rn=5 and src=2 for 5 cycles; no dlv_valid and no ack_tx_start.
REQ-034 With RECV_SEQ_CHECK_EN, src=0 sends sn=0,1, then sn=1 again -> two deliveries; the third packet gets no dlv_valid and ack_tx_rn=2. Sending sn 0..7 then 0 (SEQ_NUM_WIDTH=3) -> nine deliveries (wrap).
REQ-035 Assert rst in DELIVER and in ACK_WAIT -> next cycle IDLE with all outputs 0; the next grant is ch0; with RECV_SEQ_CHECK_EN, sn=0 is again in-order.

Source files
------------

// File: rtl/recv_ctrl_mc.sv
// Receive controller: round-robin accept of one packet per NUM_CH channels, then ACK-report, deliver and ACK-generate handshakes.
// Latency: accept at cycle T, first strobe (ack_rx_valid / dlv_valid / ack_tx_start) at T+2.
// Backpressure: pkt_ready only in IDLE; all channels stall until the packet's handshakes finish. `RECV_SEQ_CHECK_EN adds per-source in-order checking.
module recv_ctrl_mc #(
    parameter int NUM_CH        = 4,
    parameter int DFX_WIDTH     = 2,
    parameter int SEQ_NUM_WIDTH = 3,
    parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             pkt_valid,
    input  logic [NUM_CH-1:0]             pkt_type,
    input  logic [NUM_CH*DFX_WIDTH-1:0]   pkt_src_dfx,
    input  logic [NUM_CH*DFX_WIDTH-1:0]   pkt_dst_dfx,
    input  logic [NUM_CH*SEQ_NUM_WIDTH-1:0] pkt_sn,
    input  logic [NUM_CH*SEQ_NUM_WIDTH-1:0] pkt_rn,
    output logic [NUM_CH-1:0]             pkt_ready,
    output logic                          ack_rx_valid,
    output logic [SEQ_NUM_WIDTH-1:0]      ack_rx_rn,
    output logic [DFX_WIDTH-1:0]          ack_rx_src_dfx,
    input  logic                          ack_rx_ready,
    output logic                          ack_tx_start,
    output logic [DFX_WIDTH-1:0]          ack_tx_src_dfx,
    output logic [DFX_WIDTH-1:0]          ack_tx_dst_dfx,
    output logic [SEQ_NUM_WIDTH-1:0]      ack_tx_rn,
    input  logic                          ack_tx_done,
    output logic                          dlv_valid,
    output logic [DFX_WIDTH-1:0]          dlv_src_dfx,
    output logic [CH_W-1:0]               dlv_ch,
    input  logic                          dlv_done
);

    typedef enum logic [2:0] {
        IDLE, PROCESS, DELIVER, ACK_START, ACK_WAIT, ACK_RX
    } state_t;

    typedef struct packed {
        logic                     is_ack;
        logic [DFX_WIDTH-1:0]     src;
        logic [DFX_WIDTH-1:0]     dst;
        logic [SEQ_NUM_WIDTH-1:0] sn;
        logic [SEQ_NUM_WIDTH-1:0] rn;
        logic [CH_W-1:0]          ch;
    } pkt_t;

    state_t                   state, state_nxt;
    pkt_t                     cap, gnt_pkt;
    logic [CH_W-1:0]          rr_ptr, gnt_idx, rr_nxt;
    logic                     gnt_found, accept, in_order;
    logic [SEQ_NUM_WIDTH-1:0] ack_rn, ack_rn_nxt;

    function automatic logic [CH_W-1:0] ch_wrap(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return s[CH_W-1:0];
    endfunction

    // First requesting channel at or after rr_ptr wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_found && pkt_valid[ch_wrap(int'(rr_ptr), i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ch_wrap(int'(rr_ptr), i);
            end
        end
    end

    always_comb begin
        gnt_pkt.is_ack = pkt_type[gnt_idx];
        gnt_pkt.src    = pkt_src_dfx[int'(gnt_idx)*DFX_WIDTH +: DFX_WIDTH];
        gnt_pkt.dst    = pkt_dst_dfx[int'(gnt_idx)*DFX_WIDTH +: DFX_WIDTH];
        gnt_pkt.sn     = pkt_sn[int'(gnt_idx)*SEQ_NUM_WIDTH +: SEQ_NUM_WIDTH];
        gnt_pkt.rn     = pkt_rn[int'(gnt_idx)*SEQ_NUM_WIDTH +: SEQ_NUM_WIDTH];
        gnt_pkt.ch     = gnt_idx;
    end

    assign rr_nxt = ch_wrap(int'(gnt_idx), 1);
    assign accept = (state == IDLE) && gnt_found;

    always_comb begin
        pkt_ready = '0;
        if (state == IDLE && !rst && gnt_found) pkt_ready[gnt_idx] = 1'b1;
    end

`ifdef RECV_SEQ_CHECK_EN
    logic [SEQ_NUM_WIDTH-1:0] expected_sn [2**DFX_WIDTH];

    assign in_order   = (cap.sn == expected_sn[cap.src]);
    assign ack_rn_nxt = in_order ? cap.sn + SEQ_NUM_WIDTH'(1) : expected_sn[cap.src];

    // Advance only once delivery is confirmed, so an aborted delivery is retried in order
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**DFX_WIDTH; i++) expected_sn[i] <= '0;
        end else if (state == DELIVER && dlv_done) begin
            expected_sn[cap.src] <= expected_sn[cap.src] + SEQ_NUM_WIDTH'(1);
        end
    end
`else
    assign in_order   = 1'b1;
    assign ack_rn_nxt = cap.sn + SEQ_NUM_WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ack_rx_valid = 1'b0;
        dlv_valid    = 1'b0;
        ack_tx_start = 1'b0;
        case (state)
            IDLE:      if (gnt_found) state_nxt = PROCESS;
            PROCESS: begin
                if (cap.is_ack)    state_nxt = ACK_RX;
                else if (in_order) state_nxt = DELIVER;
                else               state_nxt = ACK_START;
            end
            DELIVER: begin
                dlv_valid = 1'b1;
                if (dlv_done) state_nxt = ACK_START;
            end
            ACK_START: begin
                ack_tx_start = 1'b1;
                state_nxt    = ACK_WAIT;
            end
            ACK_WAIT:  if (ack_tx_done) state_nxt = IDLE;
            ACK_RX: begin
                ack_rx_valid = 1'b1;
                if (ack_rx_ready) state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap    <= '0;
            rr_ptr <= '0;
            ack_rn <= '0;
        end else begin
            if (accept) begin
                cap    <= gnt_pkt;
                rr_ptr <= rr_nxt;
            end
            if (state == PROCESS && !cap.is_ack) ack_rn <= ack_rn_nxt;
        end
    end

    assign ack_rx_rn      = cap.rn;
    assign ack_rx_src_dfx = cap.src;
    assign ack_tx_src_dfx = cap.dst;
    assign ack_tx_dst_dfx = cap.src;
    assign ack_tx_rn      = ack_rn;
    assign dlv_src_dfx    = cap.src;
    assign dlv_ch         = cap.ch;

endmodule

// File: tb/tb_recv_ctrl_mc.sv
// Self-checking bench for recv_ctrl_mc: directed scenarios plus random packets against a transaction-level model.
module tb_recv_ctrl_mc;
    localparam int NUM_CH = 4;
    localparam int DW     = 2;
    localparam int SW     = 3;
    localparam int CW     = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic [NUM_CH-1:0]    pkt_valid = '0, pkt_type = '0, pkt_ready;
    logic [NUM_CH*DW-1:0] pkt_src_dfx = '0, pkt_dst_dfx = '0;
    logic [NUM_CH*SW-1:0] pkt_sn = '0, pkt_rn = '0;
    logic                 ack_rx_valid, ack_rx_ready = 1'b0;
    logic [SW-1:0]        ack_rx_rn, ack_tx_rn;
    logic [DW-1:0]        ack_rx_src_dfx, ack_tx_src_dfx, ack_tx_dst_dfx, dlv_src_dfx;
    logic                 ack_tx_start, ack_tx_done = 1'b0;
    logic                 dlv_valid, dlv_done = 1'b0;
    logic [CW-1:0]        dlv_ch;

    recv_ctrl_mc dut (
        .clk(clk), .rst(rst),
        .pkt_valid(pkt_valid), .pkt_type(pkt_type),
        .pkt_src_dfx(pkt_src_dfx), .pkt_dst_dfx(pkt_dst_dfx),
        .pkt_sn(pkt_sn), .pkt_rn(pkt_rn), .pkt_ready(pkt_ready),
        .ack_rx_valid(ack_rx_valid), .ack_rx_rn(ack_rx_rn),
        .ack_rx_src_dfx(ack_rx_src_dfx), .ack_rx_ready(ack_rx_ready),
        .ack_tx_start(ack_tx_start), .ack_tx_src_dfx(ack_tx_src_dfx),
        .ack_tx_dst_dfx(ack_tx_dst_dfx), .ack_tx_rn(ack_tx_rn), .ack_tx_done(ack_tx_done),
        .dlv_valid(dlv_valid), .dlv_src_dfx(dlv_src_dfx), .dlv_ch(dlv_ch), .dlv_done(dlv_done)
    );

    int n_chk = 0, n_fail = 0, n_dlv_obs = 0;

    // Model: round-robin pointer, per-source expected sequence, pending packet per channel
    int            m_rr;
    logic [SW-1:0] m_exp  [4];
    bit            ch_vld [NUM_CH];
    logic          ch_ack [NUM_CH];
    logic [DW-1:0] ch_src [NUM_CH], ch_dst [NUM_CH];
    logic [SW-1:0] ch_sn  [NUM_CH], ch_rn  [NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_CH; i++) begin
            pkt_valid[i]             = ch_vld[i];
            pkt_type[i]              = ch_ack[i];
            pkt_src_dfx[i*DW +: DW]  = ch_src[i];
            pkt_dst_dfx[i*DW +: DW]  = ch_dst[i];
            pkt_sn[i*SW +: SW]       = ch_sn[i];
            pkt_rn[i*SW +: SW]       = ch_rn[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_inputs();
        #1;
    endtask

    task automatic load(input int ch, input logic ack, input logic [DW-1:0] src,
                        input logic [DW-1:0] dst, input logic [SW-1:0] sn, input logic [SW-1:0] rn);
        ch_vld[ch] = 1'b1;
        ch_ack[ch] = ack;
        ch_src[ch] = src;
        ch_dst[ch] = dst;
        ch_sn[ch]  = sn;
        ch_rn[ch]  = rn;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"},  32'(pkt_ready), 0);
        check({tag, "_strobe"}, 32'({ack_rx_valid, dlv_valid, ack_tx_start}), 0);
        check({tag, "_rxrn"},   32'(ack_rx_rn), 0);
        check({tag, "_rxsrc"},  32'(ack_rx_src_dfx), 0);
        check({tag, "_txsrc"},  32'(ack_tx_src_dfx), 0);
        check({tag, "_txdst"},  32'(ack_tx_dst_dfx), 0);
        check({tag, "_txrn"},   32'(ack_tx_rn), 0);
        check({tag, "_dlvsrc"}, 32'(dlv_src_dfx), 0);
        check({tag, "_dlvch"},  32'(dlv_ch), 0);
    endtask

    // Reset with every channel requesting: nothing may be granted while rst is high
    task automatic do_reset(input string tag);
        rst       = 1'b1;
        pkt_valid = '1;
        @(posedge clk);
        #2;
        check_zero(tag);
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) ch_vld[i] = 1'b0;
        drive_inputs();
        ack_rx_ready = 1'b0;
        ack_tx_done  = 1'b0;
        dlv_done     = 1'b0;
        m_rr = 0;
        for (int i = 0; i < 4; i++) m_exp[i] = '0;
        #1;
    endtask

    // Accept one packet and walk it through all handshakes with the given response delays
    task automatic serve(input int rdy_dly, input int dlv_dly, input int txd_dly, input bit keep);
        int            g;
        logic [NUM_CH-1:0] exp_rdy;
        logic          c_ack;
        logic [DW-1:0] c_src, c_dst;
        logic [SW-1:0] c_sn, c_rn, e_rn;
        bit            inord;
        drive_inputs();
        #1;
        g = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (g < 0 && ch_vld[(m_rr + i) % NUM_CH]) g = (m_rr + i) % NUM_CH;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("grant", 32'(pkt_ready), 32'(exp_rdy));
        if (g < 0) return;
        c_ack = ch_ack[g]; c_src = ch_src[g]; c_dst = ch_dst[g];
        c_sn  = ch_sn[g];  c_rn  = ch_rn[g];
        m_rr  = (g + 1) % NUM_CH;
        if (!keep) ch_vld[g] = 1'b0;
        tick();
        check("process_ready",  32'(pkt_ready), 0);
        check("process_strobe", 32'({ack_rx_valid, dlv_valid, ack_tx_start}), 0);
        tick();
        if (c_ack) begin
            for (int k = 0; k <= rdy_dly; k++) begin
                ack_rx_ready = (k == rdy_dly);
                dlv_done     = 1'b1;
                check("ackrx_valid", 32'(ack_rx_valid), 1);
                check("ackrx_rn",    32'(ack_rx_rn), 32'(c_rn));
                check("ackrx_src",   32'(ack_rx_src_dfx), 32'(c_src));
                check("ackrx_other", 32'({dlv_valid, ack_tx_start}), 0);
                check("ackrx_ready", 32'(pkt_ready), 0);
                tick();
            end
            ack_rx_ready = 1'b0;
            dlv_done     = 1'b0;
            return;
        end
`ifdef RECV_SEQ_CHECK_EN
        inord = (c_sn == m_exp[c_src]);
`else
        inord = 1'b1;
`endif
        if (inord) begin
            for (int k = 0; k <= dlv_dly; k++) begin
                dlv_done = (k == dlv_dly);
                if (k == 0 && dlv_valid === 1'b1) n_dlv_obs++;
                check("dlv_valid", 32'(dlv_valid), 1);
                check("dlv_ch",    32'(dlv_ch), g);
                check("dlv_src",   32'(dlv_src_dfx), 32'(c_src));
                check("dlv_other", 32'({ack_rx_valid, ack_tx_start}), 0);
                tick();
            end
            dlv_done = 1'b0;
            e_rn = c_sn + 3'd1;
            m_exp[c_src] = m_exp[c_src] + 3'd1;
        end else begin
            e_rn = m_exp[c_src];
        end
        ack_tx_done = 1'b1;
        check("txstart",       32'(ack_tx_start), 1);
        check("txstart_src",   32'(ack_tx_src_dfx), 32'(c_dst));
        check("txstart_dst",   32'(ack_tx_dst_dfx), 32'(c_src));
        check("txstart_rn",    32'(ack_tx_rn), 32'(e_rn));
        check("txstart_other", 32'({ack_rx_valid, dlv_valid}), 0);
        tick();
        for (int k = 0; k <= txd_dly; k++) begin
            ack_tx_done = (k == txd_dly);
            check("txwait_start", 32'(ack_tx_start), 0);
            check("txwait_rn",    32'(ack_tx_rn), 32'(e_rn));
            check("txwait_src",   32'(ack_tx_src_dfx), 32'(c_dst));
            check("txwait_dst",   32'(ack_tx_dst_dfx), 32'(c_src));
            check("txwait_ready", 32'(pkt_ready), 0);
            check("txwait_dlv",   32'(dlv_valid), 0);
            tick();
        end
        ack_tx_done = 1'b0;
    endtask

    // Accept a single packet, let it run n cycles past accept, then reset mid-flight
    task automatic abort_at(input int ch, input logic [SW-1:0] sn, input int n, input string tag);
        load(ch, 1'b0, 2'd0, 2'd1, sn, 3'd0);
        drive_inputs();
        #1;
        ch_vld[ch] = 1'b0;
        for (int k = 0; k < n; k++) begin
            dlv_done = 1'b1;
            tick();
        end
        if (n == 2) check({tag, "_in_deliver"}, 32'(dlv_valid), 1);
        do_reset(tag);
    endtask

    initial begin
        int dlv_before;
        for (int i = 0; i < NUM_CH; i++) load(i, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < NUM_CH; i++) ch_vld[i] = 1'b0;
        drive_inputs();
        #2;
        do_reset("reset");

        // Data on ch2: deliver then ACK src=3 dst=1 rn=1
        load(2, 1'b0, 2'd1, 2'd3, 3'd0, 3'd0);
        serve(0, 0, 2, 1'b0);

        // All four channels requesting continuously: rotation from ch0
        do_reset("reset_rr");
        for (int i = 0; i < NUM_CH; i++) load(i, 1'b0, 2'(i), 2'(3 - i), 3'd0, 3'd0);
        for (int i = 0; i < 5; i++) serve(0, 0, 0, 1'b1);
        for (int i = 0; i < NUM_CH; i++) ch_vld[i] = 1'b0;

        // ACK packet with delayed ack_rx_ready
        load(1, 1'b1, 2'd2, 2'd0, 3'd0, 3'd5);
        serve(4, 0, 0, 1'b0);

        // Sequence check: duplicate, then full wrap of sn
        do_reset("reset_seq");
        load(0, 1'b0, 2'd0, 2'd1, 3'd0, 3'd0); serve(0, 0, 0, 1'b0);
        load(0, 1'b0, 2'd0, 2'd1, 3'd1, 3'd0); serve(0, 1, 0, 1'b0);
        load(0, 1'b0, 2'd0, 2'd1, 3'd1, 3'd0); serve(0, 0, 1, 1'b0);
        do_reset("reset_wrap");
        dlv_before = n_dlv_obs;
        for (int i = 0; i < 9; i++) begin
            load(0, 1'b0, 2'd0, 2'd2, 3'(i % 8), 3'd0);
            serve(0, 0, 0, 1'b0);
        end
        check("wrap_deliveries", n_dlv_obs - dlv_before, 9);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_vld[i] && $urandom_range(0, 1) == 1) begin
                    logic [DW-1:0] s;
                    s = 2'($urandom);
                    load(i, 1'($urandom), s, 2'($urandom),
                         ($urandom_range(0, 1) == 1) ? m_exp[s] : 3'($urandom), 3'($urandom));
                end
                if (ch_vld[i]) any = 1'b1;
            end
            if (!any) load(int'($urandom_range(0, NUM_CH - 1)), 1'b0, 2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom));
            serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end
        for (int i = 0; i < NUM_CH; i++) ch_vld[i] = 1'b0;

        // Reset mid-DELIVER: pointer back to 0
        do_reset("reset_pre");
        load(0, 1'b0, 2'd0, 2'd1, 3'd0, 3'd0); serve(0, 0, 0, 1'b0);
        abort_at(1, 3'd1, 2, "abort_dlv");
        load(0, 1'b0, 2'd0, 2'd1, 3'd0, 3'd0);
        load(2, 1'b0, 2'd3, 2'd1, 3'd0, 3'd0);
        serve(0, 0, 0, 1'b0);
        serve(0, 0, 0, 1'b0);

        // Reset mid-ACK_WAIT: sequence table cleared
        load(0, 1'b0, 2'd0, 2'd1, 3'd1, 3'd0); serve(0, 0, 0, 1'b0);
        abort_at(1, 3'd2, 4, "abort_wait");
        load(0, 1'b0, 2'd0, 2'd1, 3'd0, 3'd0);
        load(2, 1'b0, 2'd1, 2'd1, 3'd0, 3'd0);
        dlv_before = n_dlv_obs;
        serve(0, 0, 0, 1'b0);
        check("post_reset_inorder", n_dlv_obs - dlv_before, 1);
        serve(0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
